dmni_msg_injector: RTL

//  Synthesizable transmit end of the DMNI flit interface (tx/eop/credit/data).

---
 rtl/TaskInjectorPkg.sv | 19 +
 rtl/dmni_flit_mux.sv | 45 ++++
 rtl/dmni_msg_injector.sv | 132 +++++++++++++
 3 files changed

// File: rtl/TaskInjectorPkg.sv
// Shared constants for the DMNI message path: service codes and the
// fixed header layout used by both the injector and the receive-side logger.
package TaskInjectorPkg;

    // Service code carried in header flit 2 of a delivered message.
    localparam logic [31:0] MESSAGE_DELIVERY = 32'h0000_0020;

    // Header length in flits (target .. timestamp); payload starts here.
    localparam int DMNI_HDR_FLITS = 7;

    // Flit index of each header field (target sits at index 0).
    localparam int DMNI_IDX_SIZE    = 1;
    localparam int DMNI_IDX_SERVICE = 2;
    localparam int DMNI_IDX_PROD    = 3;
    localparam int DMNI_IDX_CONS    = 4;
    localparam int DMNI_IDX_LEN     = 5;
    localparam int DMNI_IDX_TS      = 6;

endpackage

// File: rtl/dmni_flit_mux.sv
// Flit selector: maps the current flit index onto the registered packet
// fields and flags the final flit of the packet.
module dmni_flit_mux
    import TaskInjectorPkg::*;
#(
    parameter int FLIT_SIZE = 32,
    parameter int IDX_W     = 7
) (
    input  logic [IDX_W-1:0]     idx_i,
    input  logic [15:0]          target_i,
    input  logic [FLIT_SIZE-1:0] producer_i,
    input  logic [FLIT_SIZE-1:0] consumer_i,
    input  logic [15:0]          len_i,
    input  logic [31:0]          timestamp_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 eop_o
);

    logic [15:0] idx16;
    logic [15:0] payload_k;

    assign idx16     = 16'(idx_i);
    assign payload_k = idx16 - 16'(DMNI_HDR_FLITS);

    // Select the flit word for the current index; anything past the header is payload.
    always_comb begin
        data_o = '0;
        case (idx16)
            16'd0:                     data_o = FLIT_SIZE'(target_i);
            16'(DMNI_IDX_SIZE):        data_o = FLIT_SIZE'(len_i + 16'(DMNI_HDR_FLITS - 2));
            16'(DMNI_IDX_SERVICE):     data_o = FLIT_SIZE'(MESSAGE_DELIVERY);
            16'(DMNI_IDX_PROD):        data_o = producer_i;
            16'(DMNI_IDX_CONS):        data_o = consumer_i;
            16'(DMNI_IDX_LEN):         data_o = FLIT_SIZE'(len_i);
            16'(DMNI_IDX_TS):          data_o = FLIT_SIZE'(timestamp_i);
            default:                   data_o = FLIT_SIZE'({producer_i[15:0], payload_k});
        endcase
    end

    // Last flit sits at index 6+L (timestamp flit when there is no payload).
    always_comb begin
        eop_o = (idx16 == len_i + 16'(DMNI_HDR_FLITS - 1));
    end

endmodule

// File: rtl/dmni_msg_injector.sv
// DMNI transmit-side traffic source: accepts a packet request, latches its
// fields and streams a MESSAGE_DELIVERY packet under credit flow control.
module dmni_msg_injector
    import TaskInjectorPkg::*;
#(
    parameter int FLIT_SIZE   = 32,
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [15:0]          req_target_i,
    input  logic [FLIT_SIZE-1:0] req_producer_i,
    input  logic [FLIT_SIZE-1:0] req_consumer_i,
    input  logic [15:0]          req_len_i,
    input  logic [63:0]          tick_cntr_i,
    output logic                 tx_o,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 busy_o,
    output logic [31:0]          sent_cnt_o
);

    localparam int IDX_W = $clog2(MAX_PAYLOAD + DMNI_HDR_FLITS);
    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [15:0]          target_reg;
    logic [FLIT_SIZE-1:0] producer_reg;
    logic [FLIT_SIZE-1:0] consumer_reg;
    logic [15:0]          len_reg;
    logic [31:0]          ts_reg;
    logic [31:0]          sent_cnt_reg;

    logic [15:0]          len_clamped;
    logic [FLIT_SIZE-1:0] mux_data;
    logic                 mux_eop;
    logic                 transfer;
    logic                 unused_tick_hi;

    // Only the low tick word becomes the timestamp.
    assign unused_tick_hi = ^tick_cntr_i[63:32];

    assign len_clamped = (req_len_i > MAX_LEN) ? MAX_LEN : req_len_i;

    dmni_flit_mux #(
        .FLIT_SIZE (FLIT_SIZE),
        .IDX_W     (IDX_W)
    ) u_flit_mux (
        .idx_i       (idx_reg),
        .target_i    (target_reg),
        .producer_i  (producer_reg),
        .consumer_i  (consumer_reg),
        .len_i       (len_reg),
        .timestamp_i (ts_reg),
        .data_o      (mux_data),
        .eop_o       (mux_eop)
    );

    // Outputs decode straight from the state register so an async reset drops them at once.
    always_comb begin
        tx_o        = (state_reg != IDLE);
        busy_o      = tx_o;
        req_ready_o = (state_reg == IDLE);
        data_o      = tx_o ? mux_data : '0;
        eop_o       = tx_o & mux_eop;
        transfer    = tx_o & credit_i;
        sent_cnt_o  = sent_cnt_reg;
    end

    // Packet FSM: request capture, flit index advance and completed-packet count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            target_reg   <= '0;
            producer_reg <= '0;
            consumer_reg <= '0;
            len_reg      <= '0;
            ts_reg       <= '0;
            sent_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid_i) begin
                        target_reg   <= req_target_i;
                        producer_reg <= req_producer_i;
                        consumer_reg <= req_consumer_i;
                        len_reg      <= len_clamped;
                        ts_reg       <= tick_cntr_i[31:0];
                        idx_reg      <= '0;
                        state_reg    <= HEADER;
                    end
                end
                HEADER: begin
                    if (transfer) begin
                        if (mux_eop) begin
                            state_reg    <= IDLE;
                            sent_cnt_reg <= sent_cnt_reg + 32'd1;
                        end else begin
                            if (idx_reg == IDX_W'(DMNI_IDX_TS)) begin
                                state_reg <= PAYLOAD;
                            end
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (transfer) begin
                        if (mux_eop) begin
                            state_reg    <= IDLE;
                            sent_cnt_reg <= sent_cnt_reg + 32'd1;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
